// File: rtl/rr_merge_if.sv
// DTI stream interface: valid/ready handshake carrying W bits of data.
// The producer holds valid and data stable until ready is seen.
interface dti_s_if #(
    parameter int W = 16
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface : dti_s_if

// File: rtl/rr_merge.sv
// rr_merge: SIZE-to-1 round-robin DTI merge; output data is {winning index, payload}.
// Define RR_MERGE_OUT_REG_EN to insert a registered output slice (1-cycle latency).
module rr_merge #(
    parameter int SIZE  = 2,
    parameter int DIN_W = 16,
    parameter int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic      clk,
    input  logic      rst,
    dti_s_if.consumer din [SIZE-1:0],
    dti_s_if.producer dout
);
    localparam int OUT_W = IDX_W + DIN_W;

    logic [SIZE-1:0]  in_valid;
    logic [DIN_W-1:0] in_data [SIZE];
    logic [SIZE-1:0]  in_ready;

    for (genvar g = 0; g < SIZE; g++) begin : g_ch
        assign in_valid[g]  = din[g].valid;
        assign in_data[g]   = din[g].data;
        assign din[g].ready = in_ready[g];
    end

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q,  grant_d;
    logic             locked_q, locked_d;

    logic [IDX_W-1:0] scan_sel;
    logic [IDX_W-1:0] sel;
    logic             arb_valid;
    logic             arb_ready;
    logic [OUT_W-1:0] arb_data;

    // Scan from the highest offset down so the lowest offset at or after rr_ptr wins.
    always_comb begin
        logic [IDX_W:0] idx_w;
        // NOTE: every variable gets a default first, so no path can infer a latch.
        scan_sel = rr_ptr_q;
        idx_w    = '0;
        for (int k = SIZE - 1; k >= 0; k--) begin
            idx_w = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
            if (idx_w >= (IDX_W + 1)'(SIZE)) begin
                idx_w = idx_w - (IDX_W + 1)'(SIZE);
            end
            if (in_valid[idx_w[IDX_W-1:0]]) begin
                scan_sel = idx_w[IDX_W-1:0];
            end
        end
    end

    assign sel       = locked_q ? grant_q : scan_sel;
    assign arb_valid = in_valid[sel];
    assign arb_data  = {sel, in_data[sel]};

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < SIZE; i++) begin
            in_ready[i] = (sel == IDX_W'(i)) && arb_ready && in_valid[i];
        end
    end

    // A stalled grant is locked so a later, higher-priority arrival cannot change the output.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        locked_d = locked_q;
        if (arb_valid && arb_ready) begin
            locked_d = 1'b0;
            rr_ptr_d = (sel == IDX_W'(SIZE - 1)) ? '0 : sel + IDX_W'(1);
        end else if (arb_valid) begin
            locked_d = 1'b1;
            grant_d  = sel;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            locked_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
        end
    end

`ifdef RR_MERGE_OUT_REG_EN
    logic             dout_valid_q;
    logic [OUT_W-1:0] dout_data_q;
    logic             slice_ready;

    assign slice_ready = !dout_valid_q || dout.ready;
    assign arb_ready   = slice_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
        end else if (slice_ready) begin
            dout_valid_q <= arb_valid;
        end
    end

    // NOTE: the data register is deliberately not reset; dout_valid_q qualifies it.
    always_ff @(posedge clk) begin
        if (slice_ready) begin
            dout_data_q <= arb_data;
        end
    end

    assign dout.valid = dout_valid_q;
    assign dout.data  = dout_data_q;
`else
    assign arb_ready  = dout.ready;
    assign dout.valid = arb_valid;
    assign dout.data  = arb_data;
`endif

endmodule : rr_merge

// File: tb/tb_rr_merge.sv
// Bench for rr_merge: directed arbitration scenarios then random traffic, checked by a
// scoreboard (per-channel expected queues) and a round-robin reference model in the monitor.
module tb_rr_merge;
    localparam int SIZE  = 4;
    localparam int DIN_W = 16;
    localparam int IDX_W = 2;
    localparam int OUT_W = IDX_W + DIN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [SIZE-1:0]  tb_valid = '0;
    logic [DIN_W-1:0] tb_data [SIZE];
    logic [SIZE-1:0]  rdy;
    logic             tb_dout_ready = 1'b0;

    dti_s_if #(.W(DIN_W)) din_if [SIZE-1:0] ();
    dti_s_if #(.W(OUT_W)) dout_if ();

    for (genvar g = 0; g < SIZE; g++) begin : g_drv
        assign din_if[g].valid = tb_valid[g];
        assign din_if[g].data  = tb_data[g];
        assign rdy[g]          = din_if[g].ready;
    end
    assign dout_if.ready = tb_dout_ready;

    rr_merge #(.SIZE(SIZE), .DIN_W(DIN_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din_if),
        .dout (dout_if)
    );

    int n_cmp = 0;
    int n_mis = 0;
    logic [OUT_W-1:0] exp_q [SIZE][$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arbitration: first valid channel at or after the priority pointer.
    function automatic int first_from(input int p, input logic [SIZE-1:0] v);
        for (int k = 0; k < SIZE; k++) begin
            if (v[(p + k) % SIZE]) return (p + k) % SIZE;
        end
        return p;
    endfunction

    // ---------------- monitor / reference model ----------------
    int               m_ptr = 0;
    bit               m_prev_stall = 1'b0;
    logic [OUT_W-1:0] m_prev_out;
    int               m_wait [SIZE];
    bit               m_rst_prev = 1'b0;
    int               m_idx;
    logic [OUT_W-1:0] m_exp;

    always @(negedge clk) begin
        if (rst) begin
            if (m_rst_prev) check("reset_dout_valid", dout_if.valid, 1'b0);
            m_ptr        = 0;
            m_prev_stall = 1'b0;
            for (int i = 0; i < SIZE; i++) m_wait[i] = 0;
        end else begin
            check("ready_at_most_one", $countones(rdy) <= 1, 1'b1);
`ifndef RR_MERGE_OUT_REG_EN
            check("dout_valid", dout_if.valid, |tb_valid);
`endif
            if (dout_if.valid) begin
                m_idx = int'(dout_if.data[OUT_W-1:DIN_W]);
                if (m_prev_stall) begin
                    check("hold_while_stalled", dout_if.data, m_prev_out);
                end
`ifndef RR_MERGE_OUT_REG_EN
                else begin
                    check("rr_winner", m_idx, first_from(m_ptr, tb_valid));
                end
                check("winner_ready", rdy[m_idx], tb_dout_ready);
`endif
                if (tb_dout_ready) begin
                    check("sb_item_expected", exp_q[m_idx].size() > 0, 1'b1);
                    if (exp_q[m_idx].size() > 0) begin
                        m_exp = exp_q[m_idx].pop_front();
                        check("sb_data", dout_if.data, m_exp);
                    end
`ifndef RR_MERGE_OUT_REG_EN
                    for (int i = 0; i < SIZE; i++) begin
                        if (i == m_idx || !tb_valid[i]) begin
                            m_wait[i] = 0;
                        end else begin
                            m_wait[i]++;
                            check("fairness_wait", m_wait[i] <= SIZE - 1, 1'b1);
                        end
                    end
`endif
                    m_ptr        = (m_idx + 1) % SIZE;
                    m_prev_stall = 1'b0;
                end else begin
                    m_prev_stall = 1'b1;
                    m_prev_out   = dout_if.data;
                end
            end else begin
                m_prev_stall = 1'b0;
            end
        end
        m_rst_prev = rst;
    end

    // ---------------- stimulus ----------------
    // Advance one cycle; channels whose handshake completed drop valid at posedge+1.
    task automatic tick();
        logic [SIZE-1:0] acc;
        @(negedge clk);
        acc = tb_valid & rdy;
        @(posedge clk);
        #1;
        tb_valid = tb_valid & ~acc;
    endtask

    task automatic offer(input int ch, input logic [DIN_W-1:0] d);
        if (!tb_valid[ch]) begin
            tb_valid[ch] = 1'b1;
            tb_data[ch]  = d;
            exp_q[ch].push_back({IDX_W'(ch), d});
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        tb_valid = '0;
        for (int i = 0; i < SIZE; i++) exp_q[i].delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int pending();
        int n = 0;
        for (int i = 0; i < SIZE; i++) n += exp_q[i].size();
        return n;
    endfunction

    initial begin
        for (int i = 0; i < SIZE; i++) tb_data[i] = '0;
        do_reset();

        // single source on channel 2
        tb_dout_ready = 1'b1;
        offer(2, 16'h00AA);
        tick();

        // wrap: pointer is now 3, channels 3 and 0 compete
        offer(3, 16'h3333);
        offer(0, 16'h0000);
        tick();
        tick();

        // lock on stall: channel 1 stalled, channel 0 arrives during the stall
        tb_dout_ready = 1'b0;
        offer(1, 16'h1111);
        tick();
        offer(0, 16'h0B0B);
        tick();
        tick();
        tb_dout_ready = 1'b1;
        tick();
        tick();

        // reset while locked on channel 2, then channels 0 and 2 compete
        tb_dout_ready = 1'b0;
        offer(2, 16'h2222);
        tick();
        tick();
        do_reset();
        tb_dout_ready = 1'b1;
        offer(0, 16'hA0A0);
        offer(2, 16'hA2A2);
        tick();
        tick();

        // all channels continuously valid for 8 cycles from a fresh pointer
        do_reset();
        tb_dout_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < SIZE; i++) offer(i, DIN_W'($urandom));
            tick();
        end

        // random traffic with random backpressure
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < SIZE; i++) begin
                if ($urandom_range(0, 99) < 55) offer(i, DIN_W'($urandom));
            end
            tb_dout_ready = ($urandom_range(0, 99) < 70);
            tick();
        end

        // drain with a bounded budget
        tb_dout_ready = 1'b1;
        for (int c = 0; c < 64 && (pending() != 0 || tb_valid != '0); c++) tick();
        check("drain_empty", pending(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule : tb_rr_merge
